// File: rtl/dma_int_event_queue_pkg.sv
// Shared constants and sizing helpers for the DMA interrupt event queue.
package dma_int_event_queue_pkg;

  localparam int DEPTH_MIN  = 2;
  localparam int DEPTH_MAX  = 256;
  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 16;

  localparam int DROP_BACKPRESSURE = 0;
  localparam int DROP_DISCARD      = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Index widths never collapse to zero bits, even for a single channel/entry.
  function automatic int min1_clog2(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/dma_int_rr_arbiter.sv
// Round-robin requester arbiter: grants the first request at or after rr_ptr.
module dma_int_rr_arbiter
  import dma_int_event_queue_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic              anyGrant
);

  localparam int CHB = min1_clog2(NUM_CH);

  logic [CHB-1:0] rr_ptr_q, rr_ptr_d;
  logic [CHB-1:0] grant_idx;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    anyGrant  = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!anyGrant && req[idx]) begin
        anyGrant   = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = CHB'(idx);
      end
    end
  end

  // The pointer only moves when the granted request actually completes.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && anyGrant) begin
      rr_ptr_d = (grant_idx == CHB'(NUM_CH - 1)) ? '0 : grant_idx + CHB'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/dma_int_event_queue.sv
// Multi-requester event FIFO: round-robin push arbitration, first-word-fall-through read,
// watermark and sticky overflow flags; full either back-pressures or discards.
module dma_int_event_queue
  import dma_int_event_queue_pkg::*;
#(
  parameter int FIFO_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int NUM_CH       = 4,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [NUM_CH-1:0]              wrReq,
  input  logic [NUM_CH*FIFO_WIDTH-1:0]   wrData,
  output logic [NUM_CH-1:0]              wrAck,
  output logic                           rdValid,
  output logic [FIFO_WIDTH-1:0]          rdData,
  output logic [min1_clog2(NUM_CH)-1:0]  rdCh,
  input  logic                           rdReady,
  input  logic [clog2(DEPTH+1)-1:0]      wMarkLevel,
  output logic [clog2(DEPTH+1)-1:0]      level,
  output logic                           fifoFull,
  output logic                           fifoEmpty,
  output logic                           wMarkFull,
  output logic                           overflow,
  input  logic                           ovfClr
);

  localparam int CHB = min1_clog2(NUM_CH);
  localparam int LVW = clog2(DEPTH + 1);
  localparam int AW  = min1_clog2(DEPTH);
  localparam int EW  = FIFO_WIDTH + CHB;

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX)
  begin : g_param_check
    $error("dma_int_event_queue: DEPTH or NUM_CH out of range");
  end

  logic [EW-1:0]         mem_q [DEPTH];
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic [LVW-1:0]        level_q, level_d;
  logic                  overflow_q, overflow_d;

  logic [NUM_CH-1:0]     grant;
  logic                  any_grant;
  logic                  is_full, pop, push, accept, drop;
  logic [CHB-1:0]        grant_idx;
  logic [FIFO_WIDTH-1:0] grant_dat;

  dma_int_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clock    (clock),
    .resetn   (resetn),
    .req      (wrReq),
    .advance  (accept),
    .grant    (grant),
    .anyGrant (any_grant)
  );

  always_comb begin
    grant_idx = '0;
    grant_dat = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        grant_idx = CHB'(k);
        grant_dat = wrData[k*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // A pop frees the slot the same cycle, so a full queue still accepts when draining.
  always_comb begin
    is_full = (level_q == LVW'(DEPTH));
    pop     = (level_q != '0) && rdReady;
    accept  = resetn && any_grant &&
              (!is_full || pop || (DROP_ON_FULL == DROP_DISCARD));
    push    = accept && (!is_full || pop);
    drop    = accept && !push;
  end

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) wr_addr_d = (wr_addr_q == AW'(DEPTH - 1)) ? '0 : wr_addr_q + AW'(1);
    if (pop)  rd_addr_d = (rd_addr_q == AW'(DEPTH - 1)) ? '0 : rd_addr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVW'(1);
      2'b01:   level_d = level_q - LVW'(1);
      default: level_d = level_q;
    endcase
    if (ovfClr) overflow_d = 1'b0;
    if (drop)   overflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_addr_q] <= {grant_idx, grant_dat};
  end

  assign {rdCh, rdData} = mem_q[rd_addr_q];
  assign wrAck     = accept ? grant : '0;
  assign rdValid   = (level_q != '0);
  assign fifoEmpty = (level_q == '0);
  assign fifoFull  = is_full;
  assign level     = level_q;
  assign wMarkFull = (level_q >= wMarkLevel);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dma_int_event_queue.sv
// Directed bench: back-pressure instance (DEPTH=5, 4 ch) and discard instance (DEPTH=4, 2 ch).
module tb_dma_int_event_queue;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  logic [3:0]  wrReq0, wrAck0;
  logic [31:0] wrData0;
  logic        rdValid0, rdReady0, full0, empty0, wmf0, ovf0, ovfClr0;
  logic [7:0]  rdData0;
  logic [1:0]  rdCh0;
  logic [2:0]  wm0, level0;

  logic [1:0]  wrReq1, wrAck1;
  logic [15:0] wrData1;
  logic        rdValid1, rdReady1, full1, empty1, wmf1, ovf1, ovfClr1;
  logic [7:0]  rdData1;
  logic [0:0]  rdCh1;
  logic [2:0]  wm1, level1;

  dma_int_event_queue #(.FIFO_WIDTH(8), .DEPTH(5), .NUM_CH(4), .DROP_ON_FULL(0)) dut0 (
    .clock(clock), .resetn(resetn), .wrReq(wrReq0), .wrData(wrData0), .wrAck(wrAck0),
    .rdValid(rdValid0), .rdData(rdData0), .rdCh(rdCh0), .rdReady(rdReady0),
    .wMarkLevel(wm0), .level(level0), .fifoFull(full0), .fifoEmpty(empty0),
    .wMarkFull(wmf0), .overflow(ovf0), .ovfClr(ovfClr0)
  );

  dma_int_event_queue #(.FIFO_WIDTH(8), .DEPTH(4), .NUM_CH(2), .DROP_ON_FULL(1)) dut1 (
    .clock(clock), .resetn(resetn), .wrReq(wrReq1), .wrData(wrData1), .wrAck(wrAck1),
    .rdValid(rdValid1), .rdData(rdData1), .rdCh(rdCh1), .rdReady(rdReady1),
    .wMarkLevel(wm1), .level(level1), .fifoFull(full1), .fifoEmpty(empty1),
    .wMarkFull(wmf1), .overflow(ovf1), .ovfClr(ovfClr1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] dat;
    logic        rdy;
    logic [3:0]  ack;
    logic [2:0]  lvl;
    logic        vld;
    logic [1:0]  ch;
    logic [7:0]  rdat;
    logic        full;
    logic        wm;
  } vec_t;

  function automatic vec_t mk(logic [3:0] req, logic [31:0] dat, logic rdy, logic [3:0] ack,
                              logic [2:0] lvl, logic vld, logic [1:0] ch, logic [7:0] rdat,
                              logic full, logic wm);
    vec_t r;
    r.req = req; r.dat = dat; r.rdy = rdy; r.ack = ack; r.lvl = lvl;
    r.vld = vld; r.ch = ch; r.rdat = rdat; r.full = full; r.wm = wm;
    return r;
  endfunction

  vec_t v [22];

  initial begin
    // Round-robin with all channels requesting, then fill to full, simultaneous push/pop, drain.
    v[0]  = mk(4'hF, 32'h44332211, 1, 4'b0001, 0, 0, 0, 8'h00, 0, 0);
    v[1]  = mk(4'hF, 32'h44332211, 1, 4'b0010, 1, 1, 0, 8'h11, 0, 0);
    v[2]  = mk(4'hF, 32'h44332211, 1, 4'b0100, 1, 1, 1, 8'h22, 0, 0);
    v[3]  = mk(4'hF, 32'h44332211, 1, 4'b1000, 1, 1, 2, 8'h33, 0, 0);
    v[4]  = mk(4'hF, 32'h44332211, 1, 4'b0001, 1, 1, 3, 8'h44, 0, 0);
    v[5]  = mk(4'hF, 32'h44332211, 1, 4'b0010, 1, 1, 0, 8'h11, 0, 0);
    v[6]  = mk(4'h0, 32'h44332211, 1, 4'b0000, 1, 1, 1, 8'h22, 0, 0);
    v[7]  = mk(4'h0, 32'h00000000, 0, 4'b0000, 0, 0, 0, 8'h00, 0, 0);
    v[8]  = mk(4'h2, 32'h00005100, 0, 4'b0010, 0, 0, 0, 8'h00, 0, 0);
    v[9]  = mk(4'h2, 32'h00005200, 0, 4'b0010, 1, 1, 1, 8'h51, 0, 0);
    v[10] = mk(4'h2, 32'h00005300, 0, 4'b0010, 2, 1, 1, 8'h51, 0, 0);
    v[11] = mk(4'h2, 32'h00005400, 0, 4'b0010, 3, 1, 1, 8'h51, 0, 1);
    v[12] = mk(4'h2, 32'h00005500, 0, 4'b0010, 4, 1, 1, 8'h51, 0, 1);
    v[13] = mk(4'h2, 32'h00005600, 0, 4'b0000, 5, 1, 1, 8'h51, 1, 1);
    v[14] = mk(4'h2, 32'h00005600, 1, 4'b0010, 5, 1, 1, 8'h51, 1, 1);
    v[15] = mk(4'h0, 32'h00000000, 1, 4'b0000, 5, 1, 1, 8'h52, 1, 1);
    v[16] = mk(4'h0, 32'h00000000, 1, 4'b0000, 4, 1, 1, 8'h53, 0, 1);
    v[17] = mk(4'h0, 32'h00000000, 1, 4'b0000, 3, 1, 1, 8'h54, 0, 1);
    v[18] = mk(4'h0, 32'h00000000, 0, 4'b0000, 2, 1, 1, 8'h55, 0, 0);
    v[19] = mk(4'h0, 32'h00000000, 1, 4'b0000, 2, 1, 1, 8'h55, 0, 0);
    v[20] = mk(4'h0, 32'h00000000, 1, 4'b0000, 1, 1, 1, 8'h56, 0, 0);
    v[21] = mk(4'h0, 32'h00000000, 0, 4'b0000, 0, 0, 0, 8'h00, 0, 0);

    resetn = 1'b0;
    wrReq0 = 4'hF; wrData0 = '0; rdReady0 = 1'b1; wm0 = 3'd3; ovfClr0 = 1'b0;
    wrReq1 = 2'b11; wrData1 = '0; rdReady1 = 1'b0; wm1 = 3'd0; ovfClr1 = 1'b0;

    #3;
    chk("rst_ack", 32'(wrAck0), 32'h0);
    chk("rst_vld", 32'(rdValid0), 32'h0);
    chk("rst_empty", 32'(empty0), 32'h1);
    chk("rst_full", 32'(full0), 32'h0);
    chk("rst_lvl", 32'(level0), 32'h0);
    chk("rst_ovf1", 32'(ovf1), 32'h0);
    chk("rst_ack1", 32'(wrAck1), 32'h0);
    #9;
    wrReq0 = 4'h0; wrReq1 = 2'b00;
    resetn = 1'b1;

    foreach (v[i]) begin
      @(posedge clock); #1;
      wrReq0 = v[i].req; wrData0 = v[i].dat; rdReady0 = v[i].rdy;
      @(negedge clock);
      chk($sformatf("v%0d_ack", i), 32'(wrAck0), 32'(v[i].ack));
      chk($sformatf("v%0d_lvl", i), 32'(level0), 32'(v[i].lvl));
      chk($sformatf("v%0d_vld", i), 32'(rdValid0), 32'(v[i].vld));
      chk($sformatf("v%0d_empty", i), 32'(empty0), 32'(!v[i].vld));
      chk($sformatf("v%0d_full", i), 32'(full0), 32'(v[i].full));
      chk($sformatf("v%0d_wm", i), 32'(wmf0), 32'(v[i].wm));
      if (v[i].vld) begin
        chk($sformatf("v%0d_ch", i), 32'(rdCh0), 32'(v[i].ch));
        chk($sformatf("v%0d_dat", i), 32'(rdData0), 32'(v[i].rdat));
      end
    end

    // Streaming push/pop pairs across several pointer wraps.
    for (int i = 0; i < 14; i++) begin
      @(posedge clock); #1;
      wrReq0   = (i < 12) ? 4'b0001 : 4'b0000;
      wrData0  = 32'(8'h80 + i);
      rdReady0 = (i < 13);
      @(negedge clock);
      if (i == 0) begin
        chk("wrap_lvl0", 32'(level0), 32'h0);
      end else if (i < 13) begin
        chk($sformatf("wrap%0d_vld", i), 32'(rdValid0), 32'h1);
        chk($sformatf("wrap%0d_dat", i), 32'(rdData0), 32'(8'h80 + i - 1));
        chk($sformatf("wrap%0d_lvl", i), 32'(level0), 32'h1);
      end else begin
        chk("wrap_end_lvl", 32'(level0), 32'h0);
      end
    end

    // Asynchronous reset with four entries queued.
    @(posedge clock); #1;
    wrReq0 = 4'b0001; wrData0 = 32'h000000C0; rdReady0 = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    chk("arst_pre_lvl", 32'(level0), 32'h4);
    resetn = 1'b0;
    #1;
    chk("arst_lvl", 32'(level0), 32'h0);
    chk("arst_vld", 32'(rdValid0), 32'h0);
    chk("arst_empty", 32'(empty0), 32'h1);
    chk("arst_full", 32'(full0), 32'h0);
    chk("arst_ack", 32'(wrAck0), 32'h0);
    @(negedge clock); #2;
    resetn = 1'b1; wrReq0 = 4'b0000; rdReady0 = 1'b1;
    @(negedge clock);
    chk("post_rst_lvl", 32'(level0), 32'h0);
    chk("post_rst_vld", 32'(rdValid0), 32'h0);
    rdReady0 = 1'b0;

    // Discard-on-full instance: fill, drop, sticky overflow, set-beats-clear.
    @(posedge clock); #1;
    wrReq1 = 2'b01; wrData1 = 16'h0010; rdReady1 = 1'b0;
    @(negedge clock);
    chk("d1_ack0", 32'(wrAck1), 32'h1);
    chk("d1_lvl0", 32'(level1), 32'h0);
    chk("d1_wm_zero", 32'(wmf1), 32'h1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clock); #1;
      wm1 = 3'd7; wrData1 = 16'(8'h10 + i);
      @(negedge clock);
      chk($sformatf("d1_ack%0d", i), 32'(wrAck1), 32'h1);
      chk($sformatf("d1_lvl%0d", i), 32'(level1), 32'(i));
    end
    @(posedge clock); #1;
    wrData1 = 16'h0014;
    @(negedge clock);
    chk("d1_drop_ack", 32'(wrAck1), 32'h1);
    chk("d1_drop_lvl", 32'(level1), 32'h4);
    chk("d1_drop_full", 32'(full1), 32'h1);
    chk("d1_drop_ovf", 32'(ovf1), 32'h0);
    chk("d1_wm_over", 32'(wmf1), 32'h0);
    @(posedge clock); #1;
    wrReq1 = 2'b00; ovfClr1 = 1'b1;
    @(negedge clock);
    chk("d1_ovf_set", 32'(ovf1), 32'h1);
    chk("d1_keep_lvl", 32'(level1), 32'h4);
    chk("d1_head", 32'(rdData1), 32'h10);
    chk("d1_head_ch", 32'(rdCh1), 32'h0);
    @(posedge clock); #1;
    wrReq1 = 2'b01; wrData1 = 16'h0015; ovfClr1 = 1'b1;
    @(negedge clock);
    chk("d1_ovf_clr", 32'(ovf1), 32'h0);
    chk("d1_drop2_ack", 32'(wrAck1), 32'h1);
    @(posedge clock); #1;
    wrReq1 = 2'b00; ovfClr1 = 1'b0;
    @(negedge clock);
    chk("d1_set_wins", 32'(ovf1), 32'h1);
    chk("d1_lvl_still", 32'(level1), 32'h4);
    @(posedge clock); #1;
    ovfClr1 = 1'b1;
    @(negedge clock);
    chk("d1_ovf_hold", 32'(ovf1), 32'h1);
    @(posedge clock); #1;
    ovfClr1 = 1'b0;
    @(negedge clock);
    chk("d1_ovf_clr2", 32'(ovf1), 32'h0);
    chk("d1_final_lvl", 32'(level1), 32'h4);
    chk("d1_final_head", 32'(rdData1), 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_int_event_queue.md
DMA_INT_EVENT_QUEUE -- requirements
Module: dma_int_event_queue

Interface
REQ-001 Parameter FIFO_WIDTH, default 8: payload width in bits per event.
REQ-002 Parameter DEPTH, default 8: queue entries; legal range 2..256; any value, power of two not required.
REQ-003 Parameter NUM_CH, default 4: write requester count; legal range 1..16.
REQ-004 Parameter DROP_ON_FULL, default 0: 0 = back-pressure when full; 1 = acknowledge and discard when full.
REQ-005 clock  in  1  rising-edge clock for all state.
REQ-006 resetn  in  1  reset, asynchronous, active-low.
REQ-007 wrReq  in  NUM_CH  per-channel push request, held until wrAck.
REQ-008 wrData  in  NUM_CH*FIFO_WIDTH  channel k payload in bits [k*FIFO_WIDTH +: FIFO_WIDTH].
REQ-009 wrAck  out  NUM_CH  one-hot, combinational; the channel whose request completes this cycle.
REQ-010 rdValid  out  1  head entry available.
REQ-011 rdData  out  FIFO_WIDTH  head payload.
REQ-012 rdCh  out  max(1,clog2(NUM_CH))  source channel of head entry.
REQ-013 rdReady  in  1  consumer accepts head; pop = rdValid & rdReady.
REQ-014 wMarkLevel  in  clog2(DEPTH+1)  programmable watermark, quasi-static.
REQ-015 level  out  clog2(DEPTH+1)  current occupancy.
REQ-016 fifoFull / fifoEmpty / wMarkFull  out  1 each  level==DEPTH / level==0 / level>=wMarkLevel.
REQ-017 overflow  out  1  sticky drop indicator; ovfClr  in  1  clears it.

Function
REQ-018 Arbitration SHALL be round-robin: pointer rrPtr; grant = first asserted wrReq at or after rrPtr, modulo NUM_CH.
REQ-019 After a grant to channel k, rrPtr SHALL become (k+1) mod NUM_CH; with no grant, rrPtr SHALL hold.
REQ-020 push SHALL occur when a grant exists and (level<DEPTH or pop this cycle); payload and channel index are stored at wrAddr.
REQ-021 DROP_ON_FULL=0: with level==DEPTH and no pop, wrAck SHALL be all zeros and rrPtr SHALL hold.
REQ-022 DROP_ON_FULL=1: with level==DEPTH and no pop, the granted channel SHALL receive wrAck, nothing is stored, and overflow SHALL set on the next edge.
REQ-023 At most one push and one pop SHALL occur per cycle.
REQ-024 Read is first-word-fall-through: rdValid = !fifoEmpty; rdData/rdCh SHALL reflect the entry at rdAddr with zero-cycle latency.
REQ-025 An entry pushed at edge n SHALL be visible on rdValid/rdData after edge n.
REQ-026 Pointers SHALL advance on push/pop and wrap from DEPTH-1 to 0.
REQ-027 Level update: push only +1; pop only -1; push and pop together unchanged.
REQ-028 Pop when empty is impossible by construction; rdReady while rdValid==0 SHALL have no effect.
REQ-029 overflow SHALL clear on ovfClr; a simultaneous set and clear SHALL leave overflow set.
REQ-030 wMarkLevel==0 SHALL make wMarkFull constantly 1; wMarkLevel>DEPTH SHALL make it constantly 0.

Reset
REQ-031 On resetn low, independent of clock: wrAddr, rdAddr, level and rrPtr SHALL go to 0, and overflow SHALL clear.
REQ-032 During reset the outputs SHALL read: rdValid=0, fifoEmpty=1, fifoFull=0, wrAck=0.
REQ-033 Storage contents SHALL NOT be reset; rdData is don't-care while rdValid==0.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries; requesters SHALL re-present after release.

Structure
REQ-035 A shared package SHALL hold the clog2 function, DROP_ON_FULL encodings, and the DEPTH/NUM_CH legal-range constants.
REQ-036 The arbiter SHALL be one sub-module, dma_int_rr_arbiter, parametrised by NUM_CH, with inputs req and advance and outputs grant and anyGrant.
REQ-037 Storage SHALL be an inferred array of DEPTH x (FIFO_WIDTH+chBits) with a synchronous write and asynchronous read.

Verification
REQ-038 NUM_CH=4, wrReq=4'b1111 held, rdReady=1 -> wrAck sequence 0001,0010,0100,1000,0001; rdCh on reads 0,1,2,3,0.
REQ-039 DEPTH=5, rdReady=0, 6 pushes -> level reaches 5, fifoFull=1, and the 6th wrAck is withheld (DROP_ON_FULL=0). Then rdReady=1 one cycle -> pop and push in the same cycle; level stays 5.
REQ-040 DROP_ON_FULL=1, full, one more request -> wrAck asserted, level stays DEPTH, overflow=1. Then ovfClr -> overflow=0.
REQ-041 DEPTH=5, 12 push/pop pairs -> data order preserved across pointer wrap; level never exceeds 1.
REQ-042 wMarkLevel=3, 3 pushes -> wMarkFull rises after the 3rd push edge. Then 1 pop -> wMarkFull falls.
REQ-043 Reset asserted asynchronously with level=4 -> level=0, rdValid=0, fifoEmpty=1 before the next clock edge.
